// File: rtl/rst_seq.sv
// Reset sequencer: synchronises several async active-low reset sources plus a
// software request, stretches them, then releases the outputs one at a time in index order.
module rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_SRC     = 2,
  parameter int NUM_OUT     = 3,
  parameter int STRETCH     = 16,
  parameter int STEP_DLY    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_rst_n,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_rst,
  output logic [NUM_OUT-1:0] rst_n_o,
  output logic               busy,
  output logic [NUM_SRC:0]   cause
);

  localparam int MAXC = (STRETCH > STEP_DLY) ? STRETCH : STEP_DLY;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_e;

  state_e                                state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q, sync_d;
  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [IW-1:0]                         idx_q, idx_d;
  logic [NUM_OUT-1:0]                    rst_n_q, rst_n_d;
  logic [NUM_SRC:0]                      cause_q, cause_d;
  logic [NUM_SRC:0]                      req;
  logic                                  act;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      cause_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      cause_q <= cause_d;
    end
  end

  // Mask is applied after the synchroniser, so mask changes act on the very next cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_rst_n};
    req    = {sw_rst, ~sync_q[SYNC_STAGES-1] & ~src_mask};
    act    = |req;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    cause_d = cause_q;
    case (state_q)
      ASSERT: begin
        rst_n_d = '0;
        cause_d = cause_q | req;
        if (act) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(STRETCH - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (act) begin
          state_d = ASSERT;
          cnt_d   = '0;
          rst_n_d = '0;
          cause_d = req;
        end else if (cnt_q == CW'(STEP_DLY - 1)) begin
          rst_n_d[idx_q] = 1'b1;
          cnt_d          = '0;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IW'(NUM_OUT - 1)) state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_n_d = '1;
        if (act) begin
          state_d = ASSERT;
          cnt_d   = '0;
          rst_n_d = '0;
          cause_d = req;
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  assign rst_n_o = rst_n_q;
  assign busy    = (state_q != RUN);
  assign cause   = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq at default parameters; edge numbers are counted
// from the last edge that samples rst high (edge 0).
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] src_rst_n;
  logic [1:0] src_mask;
  logic       sw_rst;
  logic [2:0] rst_n_o;
  logic       busy;
  logic [2:0] cause;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  rst_seq #(
    .SYNC_STAGES(2), .NUM_SRC(2), .NUM_OUT(3), .STRETCH(16), .STEP_DLY(8)
  ) dut (
    .clk(clk), .rst(rst), .src_rst_n(src_rst_n), .src_mask(src_mask),
    .sw_rst(sw_rst), .rst_n_o(rst_n_o), .busy(busy), .cause(cause)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the edge numbered 'upto'.
  task automatic tick_to(input int upto);
    while (e < upto) begin
      @(posedge clk);
      e++;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; src_rst_n = 2'b11; src_mask = 2'b00; sw_rst = 1'b0;
    e = -3;
    tick_to(0);
    chk("reset_rst_n", rst_n_o, 3'b000);
    chk("reset_busy", busy, 1'b1);
    chk("reset_cause", cause, 3'b000);
    rst = 1'b0;

    // power-up release: 26 / 34 / 42
    tick_to(25); chk("pu_pre", rst_n_o, 3'b000);
    tick_to(26); chk("pu_out0", rst_n_o, 3'b001);
    chk("pu_busy26", busy, 1'b1);
    chk("pu_cause", cause, 3'b011);
    tick_to(34); chk("pu_out1", rst_n_o, 3'b011);
    tick_to(41); chk("pu_pre2", rst_n_o, 3'b011);
    chk("pu_busy41", busy, 1'b1);
    tick_to(42); chk("pu_out2", rst_n_o, 3'b111);
    chk("pu_busy42", busy, 1'b0);

    // source 1 low for 5 cycles while in RUN
    src_rst_n = 2'b01;
    tick_to(44); chk("s1_sync", rst_n_o, 3'b111);
    tick_to(45); chk("s1_drop", rst_n_o, 3'b000);
    chk("s1_busy", busy, 1'b1);
    chk("s1_cause", cause, 3'b010);
    tick_to(47); src_rst_n = 2'b11;
    tick_to(72); chk("s1_pre", rst_n_o, 3'b000);
    tick_to(73); chk("s1_out0", rst_n_o, 3'b001);
    tick_to(81); chk("s1_out1", rst_n_o, 3'b011);
    tick_to(89); chk("s1_out2", rst_n_o, 3'b111);
    chk("s1_busy_end", busy, 1'b0);
    chk("s1_cause_held", cause, 3'b010);

    // sw_rst from RUN, then a 1-cycle glitch on source 0 during ASSERT
    sw_rst = 1'b1;
    tick_to(90); sw_rst = 1'b0;
    chk("sw_drop", rst_n_o, 3'b000);
    chk("sw_cause", cause, 3'b100);
    tick_to(99); src_rst_n = 2'b10;
    tick_to(100); src_rst_n = 2'b11;
    tick_to(102); chk("gl_cause", cause, 3'b101);
    // glitch-free release would have been at edge 114
    tick_to(114); chk("gl_no_early", rst_n_o, 3'b000);
    tick_to(125); chk("gl_pre", rst_n_o, 3'b000);
    tick_to(126); chk("gl_out0", rst_n_o, 3'b001);

    // sw_rst during RELEASE aborts and restarts from bit 0
    sw_rst = 1'b1;
    tick_to(127); sw_rst = 1'b0;
    chk("ab_drop", rst_n_o, 3'b000);
    chk("ab_busy", busy, 1'b1);
    chk("ab_cause", cause, 3'b100);
    tick_to(150); chk("ab_pre", rst_n_o, 3'b000);
    tick_to(151); chk("ab_out0", rst_n_o, 3'b001);
    tick_to(159); chk("ab_out1", rst_n_o, 3'b011);
    tick_to(167); chk("ab_out2", rst_n_o, 3'b111);
    chk("ab_busy_end", busy, 1'b0);

    // masked source held low in RUN, then unmasked
    src_mask = 2'b01; src_rst_n = 2'b10;
    tick_to(172); chk("mk_hold", rst_n_o, 3'b111);
    chk("mk_busy", busy, 1'b0);
    chk("mk_cause", cause, 3'b100);
    src_mask = 2'b00;
    tick_to(173); chk("mk_drop", rst_n_o, 3'b000);
    chk("mk_busy2", busy, 1'b1);
    chk("mk_cause2", cause, 3'b001);

    // rst overrides everything and clears cause
    src_rst_n = 2'b11; rst = 1'b1;
    tick_to(174); chk("rs_rst_n", rst_n_o, 3'b000);
    chk("rs_cause", cause, 3'b000);
    chk("rs_busy", busy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
